// File: rtl/pc_predict_pkg.sv
// Shared constants for the fetch-PC predictor: default widths, reset vector
// and the 2-bit branch-direction counter states.
package pc_predict_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        CTR_SNT = 2'd0,
        CTR_WNT = 2'd1,
        CTR_WT  = 2'd2,
        CTR_ST  = 2'd3
    } ctr_t;

endpackage

// File: rtl/pc_predict_if.sv
// Fetch-side bus of the PC predictor: pipeline control and BTB resolution
// updates in, fetch PC and prediction out.
interface pc_predict_if
    import pc_predict_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int STALL_W = 6
);

    logic [STALL_W-1:0] stall;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               upd_valid;
    logic [XLEN-1:0]    upd_pc;
    logic [XLEN-1:0]    upd_target;
    logic               upd_taken;
    logic [XLEN-1:0]    pc;
    logic               pred_taken;
    logic [XLEN-1:0]    pred_target;

    modport master (
        output stall, redirect_valid, redirect_pc,
        output upd_valid, upd_pc, upd_target, upd_taken,
        input  pc, pred_taken, pred_target
    );

    modport slave (
        input  stall, redirect_valid, redirect_pc,
        input  upd_valid, upd_pc, upd_target, upd_taken,
        output pc, pred_taken, pred_target
    );

endinterface

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: flop array with an asynchronous lookup
// port and a synchronous resolution-update port.
module pc_btb
    import pc_predict_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [BTB_ENTRIES-1:0] valid;
    ctr_t                   ctr    [BTB_ENTRIES];
    logic [TAG_W-1:0]       tag    [BTB_ENTRIES];
    logic [XLEN-3:0]        target [BTB_ENTRIES];

    logic [IDX_W-1:0] idx_l, idx_u;
    logic [TAG_W-1:0] tag_l, tag_u;
    logic             hit_l, hit_u;
    logic             unused_bits;

    function automatic ctr_t ctr_sat(input ctr_t c, input logic taken);
        if (taken) return (c == CTR_ST)  ? CTR_ST  : ctr_t'(c + 2'd1);
        else       return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
    endfunction

    // Word-aligned addresses: the two low bits never take part in index or tag.
    assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

    assign idx_l = lookup_pc[IDX_W+1:2];
    assign tag_l = lookup_pc[XLEN-1:IDX_W+2];
    assign hit_l = valid[idx_l] && (tag[idx_l] == tag_l);

    assign pred_taken  = hit_l && (ctr[idx_l] >= CTR_WT);
    assign pred_target = pred_taken ? {target[idx_l], 2'b00} : '0;

    assign idx_u = upd_pc[IDX_W+1:2];
    assign tag_u = upd_pc[XLEN-1:IDX_W+2];
    assign hit_u = valid[idx_u] && (tag[idx_u] == tag_u);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) ctr[i] <= CTR_SNT;
        end else if (upd_valid) begin
            if (hit_u) begin
                ctr[idx_u] <= ctr_sat(ctr[idx_u], upd_taken);
            end else if (upd_taken) begin
                valid[idx_u] <= 1'b1;
                ctr[idx_u]   <= CTR_WT;
            end
        end
    end

    // Tag/target rewrite on every taken resolution: same tag on a hit, new
    // occupant on a miss.
    always_ff @(posedge clk) begin
        if (!rst && upd_valid && upd_taken) begin
            tag[idx_u]    <= tag_u;
            target[idx_u] <= upd_target[XLEN-1:2];
        end
    end

endmodule

// File: rtl/pc_predict.sv
// Fetch PC register with next-PC selection: redirect, stall hold, BTB
// predicted target, or sequential PC + 4.
module pc_predict
    import pc_predict_pkg::*;
#(
    parameter int              XLEN        = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(RESET_VEC_DEF),
    parameter int              BTB_ENTRIES = 16,
    parameter int              STALL_W     = 6
) (
    input  logic   clk,
    input  logic   rst,
    pc_predict_if.slave bus
);

    logic [XLEN-1:0] pc_p0;
    logic [XLEN-1:0] pc_next;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            unused_in;

    // Only stall[0] concerns fetch; redirect targets are forced word-aligned.
    assign unused_in = ^{bus.stall, bus.redirect_pc[1:0]};

    pc_btb #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .lookup_pc   (pc_p0),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (bus.upd_valid),
        .upd_pc      (bus.upd_pc),
        .upd_target  (bus.upd_target),
        .upd_taken   (bus.upd_taken)
    );

    always_comb begin
        pc_next = pc_p0 + XLEN'(4);
        if (bus.redirect_valid) pc_next = {bus.redirect_pc[XLEN-1:2], 2'b00};
        else if (bus.stall[0])  pc_next = pc_p0;
        else if (pred_taken)    pc_next = pred_target;
    end

    // Stage p0: fetch PC register
    always_ff @(posedge clk) begin
        if (rst) pc_p0 <= RESET_VEC;
        else     pc_p0 <= pc_next;
    end

    assign bus.pc          = pc_p0;
    assign bus.pred_taken  = pred_taken;
    assign bus.pred_target = pred_target;

endmodule

// File: tb/tb_pc_predict.sv
// Self-checking bench for pc_predict: directed vector table followed by
// randomized traffic against an address-arithmetic reference model.
module tb_pc_predict;

    localparam int          N  = 16;
    localparam logic [31:0] RV = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_predict_if #(.XLEN(32), .STALL_W(6)) bus ();

    pc_predict #(
        .XLEN        (32),
        .RESET_VEC   (RV),
        .BTB_ENTRIES (N),
        .STALL_W     (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        r;
        logic [5:0]  s;
        logic        rv;
        logic [31:0] rpc;
        logic        uv;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        ut;
        logic [31:0] e_pc;
        logic        e_pt;
        logic [31:0] e_tg;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // reference model state
    logic [31:0] m_pc;
    bit          m_v   [N];
    logic [31:0] m_tag [N];
    logic [31:0] m_tgt [N];
    int          m_ctr [N];

    function automatic vec_t mk(input logic r, input logic [5:0] s, input logic rv,
                                input logic [31:0] rpc, input logic uv, input logic [31:0] upc,
                                input logic [31:0] utgt, input logic ut, input logic [31:0] e_pc,
                                input logic e_pt, input logic [31:0] e_tg);
        vec_t v;
        v.r = r; v.s = s; v.rv = rv; v.rpc = rpc; v.uv = uv; v.upc = upc;
        v.utgt = utgt; v.ut = ut; v.e_pc = e_pc; v.e_pt = e_pt; v.e_tg = e_tg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        @(negedge clk);
        rst                = t.r;
        bus.stall          = t.s;
        bus.redirect_valid = t.rv;
        bus.redirect_pc    = t.rpc;
        bus.upd_valid      = t.uv;
        bus.upd_pc         = t.upc;
        bus.upd_target     = t.utgt;
        bus.upd_taken      = t.ut;
        @(posedge clk);
        #1;
    endtask

    function automatic int midx(input logic [31:0] a);
        return int'((a >> 2) % N);
    endfunction

    function automatic logic [31:0] mtagof(input logic [31:0] a);
        return a / (4 * N);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_v[midx(a)] && (m_tag[midx(a)] == mtagof(a));
    endfunction

    function automatic bit m_pred(input logic [31:0] a);
        return m_hit(a) && (m_ctr[midx(a)] >= 2);
    endfunction

    task automatic model_step(input vec_t t);
        logic [31:0] nxt;
        int          i;
        if (t.r) begin
            m_pc = RV;
            for (int k = 0; k < N; k++) begin m_v[k] = 0; m_ctr[k] = 0; end
            return;
        end
        if (t.rv)                 nxt = t.rpc & 32'hFFFF_FFFC;
        else if (t.s[0])          nxt = m_pc;
        else if (m_pred(m_pc))    nxt = m_tgt[midx(m_pc)];
        else                      nxt = m_pc + 32'd4;
        if (t.uv) begin
            i = midx(t.upc);
            if (m_hit(t.upc)) begin
                m_ctr[i] = t.ut ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                                : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
                if (t.ut) m_tgt[i] = t.utgt & 32'hFFFF_FFFC;
            end else if (t.ut) begin
                m_v[i]   = 1;
                m_tag[i] = mtagof(t.upc);
                m_tgt[i] = t.utgt & 32'hFFFF_FFFC;
                m_ctr[i] = 2;
            end
        end
        m_pc = nxt;
    endtask

    function automatic logic [31:0] rnd_addr();
        return (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 15)) << 2);
    endfunction

    initial begin
        vec_t t;
        logic [31:0] e_tg;
        bit          e_pt;

        bus.stall = '0; bus.redirect_valid = 0; bus.redirect_pc = '0;
        bus.upd_valid = 0; bus.upd_pc = '0; bus.upd_target = '0; bus.upd_taken = 0;

        // reset and free-run
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h104, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h108, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h10C, 0, 0));
        // stall and redirect while stalled
        tbl.push_back(mk(0, 0, 1, 32'h20, 0, 0, 0, 0, 32'h20, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h20, 0, 0));
        tbl.push_back(mk(0, 1, 1, 32'h403, 0, 0, 0, 0, 32'h400, 0, 0));
        // allocate and predict
        tbl.push_back(mk(0, 1, 0, 0, 1, 32'h40, 32'h80, 1, 32'h400, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h40, 0, 0, 0, 0, 32'h40, 1, 32'h80));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h80, 0, 0));
        // saturate down, then up
        tbl.push_back(mk(0, 1, 0, 0, 1, 32'h40, 32'h80, 0, 32'h80, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 32'h40, 32'h80, 0, 32'h80, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h40, 0, 0, 0, 0, 32'h40, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h44, 0, 0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 1, 0, 0, 1, 32'h40, 32'h80, 1, 32'h44, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h40, 0, 0, 0, 0, 32'h40, 1, 32'h80));
        tbl.push_back(mk(0, 1, 0, 0, 1, 32'h40, 32'h80, 0, 32'h40, 1, 32'h80));
        tbl.push_back(mk(0, 1, 0, 0, 1, 32'h40, 32'h80, 0, 32'h40, 0, 0));
        // aliasing on index 0
        tbl.push_back(mk(0, 1, 0, 0, 1, 32'h440, 32'h200, 1, 32'h40, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h440, 0, 0, 0, 0, 32'h440, 1, 32'h200));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h200, 0, 0));
        // same-cycle lookup/update hazard
        tbl.push_back(mk(0, 1, 0, 0, 1, 32'h40, 32'h80, 1, 32'h200, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h40, 0, 0, 0, 0, 32'h40, 1, 32'h80));
        tbl.push_back(mk(0, 0, 0, 0, 1, 32'h40, 32'h80, 0, 32'h80, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h40, 0, 0, 0, 0, 32'h40, 0, 0));
        // wrap
        tbl.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        // reset discards concurrent redirect/update and clears entries
        tbl.push_back(mk(1, 0, 1, 32'h500, 1, 32'h0, 32'h300, 1, 32'h100, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h40, 0, 0, 0, 0, 32'h40, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            chk($sformatf("vec%0d pc", i), bus.pc, tbl[i].e_pc);
            chk($sformatf("vec%0d pred_taken", i), 32'(bus.pred_taken), 32'(tbl[i].e_pt));
            chk($sformatf("vec%0d pred_target", i), bus.pred_target, tbl[i].e_tg);
        end

        // randomized traffic, starting from a reset
        t = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_step(t);
        apply(t);
        for (int i = 0; i < 3000; i++) begin
            t.r    = ($urandom_range(0, 199) == 0);
            t.s    = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) t.s[0] = 1'b0;
            t.rv   = ($urandom_range(0, 6) == 0);
            t.rpc  = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC
                                                 : (rnd_addr() | 32'($urandom_range(0, 3)));
            t.uv   = ($urandom_range(0, 1) == 1);
            t.upc  = rnd_addr();
            t.utgt = rnd_addr() | 32'($urandom_range(0, 3));
            t.ut   = ($urandom_range(0, 4) < 3);
            model_step(t);
            apply(t);
            e_pt = m_pred(m_pc);
            e_tg = e_pt ? m_tgt[midx(m_pc)] : 32'h0;
            chk($sformatf("rnd%0d pc", i), bus.pc, m_pc);
            chk($sformatf("rnd%0d pred_taken", i), 32'(bus.pred_taken), 32'(e_pt));
            chk($sformatf("rnd%0d pred_target", i), bus.pred_target, e_tg);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_predict.md
PC_PREDICT -- requirements
Module: pc_predict

Interface
REQ-001 Parameter XLEN, default 32, PC width in bits.
REQ-002 Parameter RESET_VEC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 Parameter BTB_ENTRIES, default 16, number of direct-mapped BTB entries; power of 2, minimum 2.
REQ-004 Parameter STALL_W, default 6, width of pipeline stall vector.
REQ-005 clk  input  1  clock; all state updates on posedge clk.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 stall  input  STALL_W  pipeline stall vector; bit 0 freezes PC advance.
REQ-008 redirect_valid  input  1  execute-stage redirect (mispredict, jump, branch resolved).
REQ-009 redirect_pc  input  XLEN  redirect target.
REQ-010 upd_valid  input  1  branch resolution update to the BTB.
REQ-011 upd_pc  input  XLEN  PC of the resolved branch.
REQ-012 upd_target  input  XLEN  resolved taken target.
REQ-013 upd_taken  input  1  resolved direction, 1 = taken.
REQ-014 pc  output  XLEN  current fetch PC, registered.
REQ-015 pred_taken  output  1  BTB predicts taken for current pc (combinational from pc).
REQ-016 pred_target  output  XLEN  predicted target for current pc; 0 when pred_taken = 0.

Function
REQ-017 Next-PC priority SHALL be: rst > redirect_valid > stall[0] (hold) > pred_taken (pred_target) > pc + 4.
REQ-018 redirect_valid SHALL load redirect_pc with bits [1:0] forced to 0 on the next edge, regardless of stall.
REQ-019 pc + 4 SHALL wrap modulo 2^XLEN (all-ones-minus-3 to 0); no overflow flag.
REQ-020 Index = pc[IDX_W+1:2], IDX_W = log2(BTB_ENTRIES); tag = pc[XLEN-1:IDX_W+2].
REQ-021 Each entry SHALL hold valid, tag, target (XLEN, bits [1:0] stored as 0), and a 2-bit saturating counter.
REQ-022 Lookup hit SHALL require valid = 1 and tag match; pred_taken = hit AND counter >= 2.
REQ-023 Counter encoding: 0 strong-not-taken, 1 weak-not-taken, 2 weak-taken, 3 strong-taken.
REQ-024 Update on hit SHALL increment (taken) or decrement (not taken) counter, saturating at 3 and 0.
REQ-025 Update on hit with upd_taken = 1 SHALL overwrite target with upd_target.
REQ-026 Update on miss with upd_taken = 1 SHALL allocate: valid = 1, tag written, target written, counter = 2; prior occupant is replaced.
REQ-027 Update on miss with upd_taken = 0 SHALL leave the entry unchanged.
REQ-028 BTB updates SHALL apply on the edge where upd_valid = 1, independent of stall and redirect_valid.
REQ-029 Lookup and update on the same entry in the same cycle: lookup SHALL see pre-update contents; new contents are visible from the next cycle.
REQ-030 Exactly one BTB entry SHALL be written per update; no other entry changes.

Reset
REQ-031 rst = 1 on a posedge SHALL set pc = RESET_VEC and clear all valid bits and counters to 0, overriding all other inputs.
REQ-032 After reset, pred_taken = 0 and pred_target = 0 until an allocating update occurs.
REQ-033 rst asserted mid-operation SHALL discard any concurrent redirect or update in that cycle.

Structure
REQ-034 XLEN default, RESET_VEC default, and the four counter-state constants SHALL be defined in the shared define header used by the core.
REQ-035 The BTB array (storage, lookup, update, counter logic) SHALL be a sub-module named pc_btb; pc_predict holds the PC register and next-PC mux.
REQ-036 The BTB SHALL be implemented as flops with a synchronous write port and an asynchronous read port.

Verification
REQ-037 Reset: rst = 1 for 2 cycles with RESET_VEC = 0x100 -> pc = 0x100, pred_taken = 0; then free-run -> pc = 0x104, 0x108, 0x10C.
REQ-038 Stall/redirect: stall[0] = 1 at pc = 0x20 -> pc holds 0x20; redirect_valid = 1 with redirect_pc = 0x403 while stalled -> pc = 0x400 next cycle.
REQ-039 Allocate/predict: upd_valid, upd_pc = 0x40, upd_target = 0x80, upd_taken = 1; later fetch at 0x40 -> pred_taken = 1, pred_target = 0x80, next pc = 0x80.
REQ-040 Saturation: after allocation (counter 2), two not-taken updates at 0x40 -> counter 0, pred_taken = 0, next pc = 0x44; four taken updates -> counter 3, a fifth keeps 3.
REQ-041 Aliasing/wrap: BTB_ENTRIES = 16, allocate 0x40 then taken update at 0x440 (same index) -> 0x440 predicts, 0x40 misses; pc = 0xFFFF_FFFC, no hit -> pc = 0x0000_0000.
REQ-042 Same-cycle hazard: at pc = 0x40 with counter 2, not-taken update to 0x40 in same cycle -> pred_taken = 1 this cycle, next pc = 0x80; a later fetch at 0x40 sees counter 1, pred_taken = 0.
